// File: rtl/cga_intr_pkg.sv
// Shared types and constants for the interrupt-controller vector generator.
// The candidate record packs both half-encoder results so they load atomically.
package cga_intr_pkg;

  localparam int CGA_INTR_LEVELS = 16;
  localparam int CGA_INTR_HALF   = 8;
  localparam int CGA_INTR_VEC_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_VALID  = 2'd2,
    ST_HOLD   = 2'd3
  } vg_state_e;

  typedef struct packed {
    logic [CGA_INTR_VEC_W-1:0] hivec;
    logic                      hif;
    logic [CGA_INTR_VEC_W-1:0] lovec;
    logic                      lof;
  } cand_t;

  function automatic logic cand_found(input cand_t c);
    return c.hif | c.lof;
  endfunction

endpackage

// File: rtl/cga_intr_prio8.sv
// 8-to-3 priority encoder: highest set request wins; vec is 0 when nothing is found.
module cga_intr_prio8
  import cga_intr_pkg::*;
(
  input  logic [CGA_INTR_HALF-1:0]  req,
  output logic [CGA_INTR_VEC_W-1:0] vec,
  output logic                      found
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a latch.
    vec   = '0;
    found = 1'b0;
    for (int i = 0; i < CGA_INTR_HALF; i++) begin
      if (req[i]) begin
        vec   = CGA_INTR_VEC_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cga_intr_cntlr_vecgen_prio.sv
// Masked, priority-encoded and debounced interrupt vector candidate for the VECGEN status stage.
// Optional program-level masking is enabled by defining CGA_INTR_VECGEN_PIL_MASK_EN.
module cga_intr_cntlr_vecgen_prio
  import cga_intr_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 2
) (
  input  logic                       MCLK,
  input  logic                       RST_N,
  input  logic [CGA_INTR_LEVELS-1:0] PID_15_0,
  input  logic [CGA_INTR_LEVELS-1:0] PIE_15_0,
  input  logic [3:0]                 PIL_3_0,
  input  logic                       FREEZE,
  output logic [CGA_INTR_VEC_W-1:0]  HIVEC_2_0,
  output logic [CGA_INTR_VEC_W-1:0]  LOVEC_2_0,
  output logic                       HIF,
  output logic                       LOF,
  output logic                       VALID,
  output logic                       VCHG
);

  logic [CGA_INTR_LEVELS-1:0] lvl_mask;
  logic [CGA_INTR_LEVELS-1:0] m_q;
  cand_t                      cand, cand_q, cand_d, out_q, out_d;
  vg_state_e                  state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_inc;
  logic                       load;
  logic                       vchg_q;

`ifdef CGA_INTR_VECGEN_PIL_MASK_EN
  // Only levels strictly above the current program level may compete.
  always_comb begin
    lvl_mask = '0;
    for (int i = 0; i < CGA_INTR_LEVELS; i++) begin
      lvl_mask[i] = (i > int'(PIL_3_0));
    end
  end
`else
  logic unused_pil;
  assign lvl_mask   = '1;
  assign unused_pil = ^PIL_3_0;
`endif

  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      m_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      m_q <= PID_15_0 & PIE_15_0 & lvl_mask;
    end
  end

  cga_intr_prio8 u_prio_hi (
    .req   (m_q[CGA_INTR_LEVELS-1:CGA_INTR_HALF]),
    .vec   (cand.hivec),
    .found (cand.hif)
  );

  cga_intr_prio8 u_prio_lo (
    .req   (m_q[CGA_INTR_HALF-1:0]),
    .vec   (cand.lovec),
    .found (cand.lof)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cand != out_q && !FREEZE) begin
          cand_d  = cand;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // Any movement of the candidate restarts the stability window.
        if (cand != cand_q) begin
          cand_d = cand;
          cnt_d  = '0;
        end else if (!FREEZE) begin
          if (cnt_inc == CNT_W'(SETTLE_CYCLES)) begin
            out_d   = cand_q;
            load    = 1'b1;
            cnt_d   = '0;
            state_d = cand_found(cand_q) ? ST_VALID : ST_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_VALID: begin
        if (FREEZE) begin
          state_d = ST_HOLD;
        end else if (cand != out_q) begin
          cand_d  = cand;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_HOLD: begin
        if (!FREEZE) state_d = ST_VALID;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      vchg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      vchg_q  <= load;
    end
  end

  assign HIVEC_2_0 = out_q.hivec;
  assign HIF       = out_q.hif;
  assign LOVEC_2_0 = out_q.lovec;
  assign LOF       = out_q.lof;
  assign VALID     = cand_found(out_q);
  assign VCHG      = vchg_q;

endmodule
